// File: rtl/point_pkg.sv
// Shared types and widths for the point sprite motion generator.
package point_pkg;

  localparam int unsigned POS_W   = 9;
  localparam int unsigned SPEED_W = 3;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned SUM_W   = POS_W + 1;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_CALC_X = 2'd1,
    ST_CALC_Y = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage : point_pkg

// File: rtl/point_axis_step.sv
// One-axis step with edge bounce: advances pos by speed in dir and clamps at 0 or limit.
module point_axis_step
  import point_pkg::*;
(
  input  logic [POS_W-1:0]   pos,
  input  logic               dir,
  input  logic [SPEED_W-1:0] speed,
  input  logic               hold,
  input  logic [POS_W-1:0]   limit,
  output logic [POS_W-1:0]   npos_c,
  output logic               ndir_c
);

  logic [SUM_W-1:0] sum;

  // Reaching a limit exactly counts as a bounce, so both comparisons are inclusive.
  always_comb begin
    npos_c = pos;
    ndir_c = dir;
    sum    = SUM_W'(pos) + SUM_W'(speed);
    if (!hold && (speed != '0)) begin
      if (!dir) begin
        if (sum >= SUM_W'(limit)) begin
          npos_c = limit;
          ndir_c = 1'b1;
        end else begin
          npos_c = POS_W'(sum);
        end
      end else begin
        if (pos <= POS_W'(speed)) begin
          npos_c = '0;
          ndir_c = 1'b0;
        end else begin
          npos_c = pos - POS_W'(speed);
        end
      end
    end
  end

endmodule : point_axis_step

// File: rtl/point_motion.sv
// Per-frame sprite position generator: on each vsync rising edge steps both axes,
// bounces off screen edges and commits the new position during vertical blanking.
module point_motion
  import point_pkg::*;
#(
  parameter int unsigned SCREEN_W = 256,
  parameter int unsigned SCREEN_H = 240,
  parameter int unsigned SPRITE_W = 16,
  parameter int unsigned SPRITE_H = 16,
  parameter int unsigned INIT_X   = 128,
  parameter int unsigned INIT_Y   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               hold,
  input  logic [SPEED_W-1:0] speed_x,
  input  logic [SPEED_W-1:0] speed_y,
  output logic [POS_W-1:0]   point_x,
  output logic [POS_W-1:0]   point_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               bounce,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned XMAX = SCREEN_W - SPRITE_W;
  localparam int unsigned YMAX = SCREEN_H - SPRITE_H;
  localparam logic [POS_W-1:0] XMAX_P = POS_W'(XMAX);
  localparam logic [POS_W-1:0] YMAX_P = POS_W'(YMAX);
  localparam logic [POS_W-1:0] INIT_X_P = POS_W'(INIT_X);
  localparam logic [POS_W-1:0] INIT_Y_P = POS_W'(INIT_Y);

  state_e               state_q, state_d;
  logic                 vsync_q;
  logic [SPEED_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic                 hld_q, hld_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [POS_W-1:0]     nx_q, nx_d, ny_q, ny_d;
  logic                 ndx_q, ndx_d, ndy_q, ndy_d;
  logic [POS_W-1:0]     point_x_q, point_x_d, point_y_q, point_y_d;
  logic                 dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic                 bounce_q, bounce_d;

  logic                 tick_c;
  logic [POS_W-1:0]     npos_x_c, npos_y_c;
  logic                 ndir_x_c, ndir_y_c;

  assign tick_c = vsync & ~vsync_q;

  point_axis_step u_step_x (
    .pos    (point_x_q),
    .dir    (dir_x_q),
    .speed  (sx_q),
    .hold   (hld_q),
    .limit  (XMAX_P),
    .npos_c (npos_x_c),
    .ndir_c (ndir_x_c)
  );

  point_axis_step u_step_y (
    .pos    (point_y_q),
    .dir    (dir_y_q),
    .speed  (sy_q),
    .hold   (hld_q),
    .limit  (YMAX_P),
    .npos_c (npos_y_c),
    .ndir_c (ndir_y_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_WAIT;
      vsync_q     <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
      hld_q       <= 1'b0;
      frame_cnt_q <= '0;
      nx_q        <= INIT_X_P;
      ny_q        <= INIT_Y_P;
      ndx_q       <= 1'b0;
      ndy_q       <= 1'b0;
      point_x_q   <= INIT_X_P;
      point_y_q   <= INIT_Y_P;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      bounce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hld_q       <= hld_d;
      frame_cnt_q <= frame_cnt_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      ndx_q       <= ndx_d;
      ndy_q       <= ndy_d;
      point_x_q   <= point_x_d;
      point_y_q   <= point_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      bounce_q    <= bounce_d;
    end
  end

  // Bounce is registered on entry to COMMIT so the pulse occupies exactly the COMMIT cycle.
  always_comb begin
    state_d     = state_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    hld_d       = hld_q;
    frame_cnt_d = frame_cnt_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    ndx_d       = ndx_q;
    ndy_d       = ndy_q;
    point_x_d   = point_x_q;
    point_y_d   = point_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    bounce_d    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (tick_c) begin
          sx_d        = speed_x;
          sy_d        = speed_y;
          hld_d       = hold;
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          state_d     = ST_CALC_X;
        end
      end
      ST_CALC_X: begin
        nx_d    = npos_x_c;
        ndx_d   = ndir_x_c;
        state_d = ST_CALC_Y;
      end
      ST_CALC_Y: begin
        ny_d     = npos_y_c;
        ndy_d    = ndir_y_c;
        bounce_d = (ndx_q != dir_x_q) | (ndir_y_c != dir_y_q);
        state_d  = ST_COMMIT;
      end
      ST_COMMIT: begin
        point_x_d = nx_q;
        point_y_d = ny_q;
        dir_x_d   = ndx_q;
        dir_y_d   = ndy_q;
        state_d   = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign point_x   = point_x_q;
  assign point_y   = point_y_q;
  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;
  assign bounce    = bounce_q;
  assign frame_cnt = frame_cnt_q;

endmodule : point_motion

// File: tb/tb_point_motion.sv
// Directed bench for point_motion: walks the sprite into every edge with hand-computed positions.
module tb_point_motion;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       hold;
  logic [2:0] speed_x;
  logic [2:0] speed_y;
  logic [8:0] point_x;
  logic [8:0] point_y;
  logic       dir_x;
  logic       dir_y;
  logic       bounce;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int bounce_cnt = 0;

  point_motion dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .hold      (hold),
    .speed_x   (speed_x),
    .speed_y   (speed_y),
    .point_x   (point_x),
    .point_y   (point_y),
    .dir_x     (dir_x),
    .dir_y     (dir_y),
    .bounce    (bounce),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts bounce-high cycles, so a stretched pulse shows up as a count above one.
  always @(negedge clk) if (bounce === 1'b1) bounce_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run_frame(input logic h, input logic [2:0] sx, input logic [2:0] sy);
    @(negedge clk);
    hold = h; speed_x = sx; speed_y = sy; vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_pos(input string tag, input int x, input int y, input int dx, input int dy);
    chk({tag, "_x"}, 32'(point_x), 32'(x));
    chk({tag, "_y"}, 32'(point_y), 32'(y));
    chk({tag, "_dx"}, 32'(dir_x), 32'(dx));
    chk({tag, "_dy"}, 32'(dir_y), 32'(dy));
  endtask

  initial begin
    reset = 1'b0; vsync = 1'b0; hold = 1'b0; speed_x = '0; speed_y = '0;
    repeat (3) @(negedge clk);
    chk_pos("rst", 128, 128, 0, 0);
    chk("rst_bounce", 32'(bounce), 0);
    chk("rst_frame", 32'(frame_cnt), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_pos("idle", 128, 128, 0, 0);

    // Straight move with latency: unchanged after 3 edges, updated after the 4th.
    bounce_cnt = 0;
    hold = 1'b0; speed_x = 3'd3; speed_y = 3'd2; vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_x_before", 32'(point_x), 128);
    @(negedge clk);
    chk("lat_x_after", 32'(point_x), 131);
    chk("lat_y_after", 32'(point_y), 130);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    chk_pos("straight", 131, 130, 0, 0);
    chk("straight_bounce", 32'(bounce_cnt), 0);
    chk("straight_frame", 32'(frame_cnt), 1);

    // Walk to (238,222) without touching an edge.
    for (int i = 0; i < 13; i++) run_frame(1'b0, 3'd7, 3'd7);
    chk_pos("walk13", 222, 221, 0, 0);
    run_frame(1'b0, 3'd7, 3'd1);
    run_frame(1'b0, 3'd7, 3'd0);
    run_frame(1'b0, 3'd2, 3'd0);
    chk_pos("pre_rb", 238, 222, 0, 0);
    chk("pre_rb_bounce", 32'(bounce_cnt), 0);

    bounce_cnt = 0;
    run_frame(1'b0, 3'd3, 3'd3);
    chk_pos("rb", 240, 224, 1, 1);
    chk("rb_bounce", 32'(bounce_cnt), 1);
    chk("rb_frame", 32'(frame_cnt), 18);

    // Walk back to (2,1) moving left/up.
    bounce_cnt = 0;
    for (int i = 0; i < 31; i++) run_frame(1'b0, 3'd7, 3'd7);
    chk_pos("walk31", 23, 7, 1, 1);
    run_frame(1'b0, 3'd7, 3'd6);
    run_frame(1'b0, 3'd7, 3'd0);
    run_frame(1'b0, 3'd7, 3'd0);
    chk_pos("pre_lt", 2, 1, 1, 1);
    chk("pre_lt_bounce", 32'(bounce_cnt), 0);

    bounce_cnt = 0;
    run_frame(1'b0, 3'd5, 3'd1);
    chk_pos("lt", 0, 0, 0, 0);
    chk("lt_bounce", 32'(bounce_cnt), 1);
    chk("lt_frame", 32'(frame_cnt), 53);

    // Hold and zero speed: frames counted, no motion.
    bounce_cnt = 0;
    for (int i = 0; i < 3; i++) run_frame(1'b1, 3'd7, 3'd7);
    chk_pos("hold", 0, 0, 0, 0);
    chk("hold_frame", 32'(frame_cnt), 56);
    for (int i = 0; i < 3; i++) run_frame(1'b0, 3'd0, 3'd0);
    chk_pos("zero", 0, 0, 0, 0);
    chk("zero_frame", 32'(frame_cnt), 59);
    chk("hold_bounce", 32'(bounce_cnt), 0);

    // Level-high vsync triggers exactly one update.
    @(negedge clk);
    hold = 1'b0; speed_x = 3'd1; speed_y = 3'd1; vsync = 1'b1;
    repeat (1000) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    chk_pos("level", 1, 1, 0, 0);
    chk("level_frame", 32'(frame_cnt), 60);

    // Frame counter wrap.
    for (int i = 0; i < 196; i++) run_frame(1'b1, 3'd7, 3'd7);
    chk("wrap_frame", 32'(frame_cnt), 0);
    chk_pos("wrap", 1, 1, 0, 0);

    // Reset during COMMIT discards the in-flight update.
    @(negedge clk);
    hold = 1'b0; speed_x = 3'd3; speed_y = 3'd3; vsync = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_pos("midrst", 128, 128, 0, 0);
    chk("midrst_frame", 32'(frame_cnt), 0);
    @(negedge clk);
    vsync = 1'b0;
    chk_pos("midrst_next", 128, 128, 0, 0);
    chk("midrst_bounce", 32'(bounce), 0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk_pos("post_rst", 128, 128, 0, 0);
    chk("post_rst_frame", 32'(frame_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_point_motion
